// File: rtl/lutnet_seq_pkg.sv
// Shared types and helpers for the LogicNets readout front-end sequencer.
package lutnet_seq_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    RESYNC  = 2'd2
  } seq_state_e;

  localparam int DEF_FEAT_W = 2;
  localparam int DEF_OUT_W  = 2;

  // Lowest bit of the frame_vec slice owned by a given feature beat.
  function automatic int slice_lo(input int beat, input int feat_w);
    return beat * feat_w;
  endfunction

endpackage

// File: rtl/lutnet_valid_pipe.sv
// Valid-token shift register that follows the external LUT layer registers
// and produces their capture enables; one common advance freezes every stage.
module lutnet_valid_pipe #(
  parameter int NUM_LAYERS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch_i,
  input  logic                  m_ready_i,
  output logic                  advance_o,
  output logic                  m_valid_o,
  output logic [NUM_LAYERS-1:0] stage_en_o
);

  logic [NUM_LAYERS-1:0] v_q, v_d;

  assign advance_o = ~(v_q[NUM_LAYERS-1] & ~m_ready_i);
  assign m_valid_o = v_q[NUM_LAYERS-1];

  always_comb begin
    v_d        = v_q;
    stage_en_o = '0;
    if (advance_o) begin
      v_d[0]        = launch_i;
      stage_en_o[0] = launch_i;
      for (int k = 1; k < NUM_LAYERS; k++) begin
        v_d[k]        = v_q[k-1];
        stage_en_o[k] = v_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

endmodule

// File: rtl/lutnet_layer_sequencer.sv
// Frame assembler and layer-pipeline sequencer for the LogicNets readout net.
// Optional statistics counters are built when LUTNET_SEQ_STATS_EN is defined.
module lutnet_layer_sequencer
  import lutnet_seq_pkg::*;
#(
  parameter int FEAT_W     = DEF_FEAT_W,
  parameter int NUM_FEAT   = 16,
  parameter int NUM_LAYERS = 3,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic [FEAT_W*NUM_FEAT-1:0] frame_vec,
  output logic [NUM_LAYERS-1:0]      stage_en,
  input  logic [OUT_W-1:0]           net_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUT_W-1:0]           m_data,
  output logic                       frame_err,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic [CNT_W-1:0]           err_cnt
);

  localparam int BC_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(NUM_FEAT - 1);

  seq_state_e                 state_q, state_d;
  logic [BC_W-1:0]            beat_cnt_q, beat_cnt_d;
  logic [FEAT_W*NUM_FEAT-1:0] frame_vec_q, frame_vec_d;
  logic                       frame_err_q, frame_err_d;
  logic                       accept, launch, advance;

  assign s_ready   = (state_q != LAUNCH);
  assign accept    = s_valid & s_ready;
  assign launch    = (state_q == LAUNCH);
  assign frame_vec = frame_vec_q;
  assign frame_err = frame_err_q;
  assign m_data    = net_out;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    frame_vec_d = frame_vec_q;
    frame_err_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          frame_vec_d[slice_lo(int'(beat_cnt_q), FEAT_W) +: FEAT_W] = s_data;
          beat_cnt_d = beat_cnt_q + BC_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            if (s_last) begin
              state_d = LAUNCH;
            end else begin
              frame_err_d = 1'b1;
              state_d     = RESYNC;
            end
          end else if (s_last) begin
            beat_cnt_d  = '0;
            frame_err_d = 1'b1;
          end
        end
      end
      // frame_vec is frozen here until the layer-0 register has captured it
      LAUNCH: begin
        if (advance) state_d = COLLECT;
      end
      RESYNC: begin
        if (accept && s_last) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      beat_cnt_q  <= '0;
      frame_vec_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_vec_q <= frame_vec_d;
      frame_err_q <= frame_err_d;
    end
  end

  lutnet_valid_pipe #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .launch_i  (launch),
    .m_ready_i (m_ready),
    .advance_o (advance),
    .m_valid_o (m_valid),
    .stage_en_o(stage_en)
  );

`ifdef LUTNET_SEQ_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (m_valid && m_ready) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if (frame_err_d)        err_cnt_q   <= err_cnt_q + CNT_W'(1);
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_lutnet_layer_sequencer.sv
// Bench for lutnet_layer_sequencer: a toy 3-layer network sits behind stage_en,
// and every delivered class code is compared with a queue of frame results.
module tb_lutnet_layer_sequencer;

  localparam int FW = 2;
  localparam int NF = 16;
  localparam int NL = 3;
  localparam int OW = 2;
  localparam int CW = 16;
  localparam int VW = FW * NF;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [FW-1:0] s_data;
  logic [VW-1:0] frame_vec;
  logic [NL-1:0] stage_en;
  logic [OW-1:0] net_out;
  logic          m_valid, m_ready, frame_err;
  logic [OW-1:0] m_data;
  logic [CW-1:0] frame_cnt, err_cnt;

  lutnet_layer_sequencer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .frame_vec(frame_vec), .stage_en(stage_en), .net_out(net_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Toy LUT network: three layer functions captured on the DUT's enables.
  function automatic logic [31:0] f0(input logic [31:0] v);
    return v ^ {v[20:0], v[31:21]};
  endfunction
  function automatic logic [31:0] f1(input logic [31:0] x);
    return x * 32'h9E3779B1 + 32'h7;
  endfunction
  function automatic logic [OW-1:0] f2(input logic [31:0] x);
    return x[31:30] ^ x[17:16] ^ x[3:2];
  endfunction
  function automatic logic [OW-1:0] ref_class(input logic [VW-1:0] v);
    return f2(f1(f0(v)));
  endfunction

  logic [31:0]   l0_q, l1_q;
  logic [OW-1:0] l2_q;
  always @(posedge clk) begin
    if (stage_en[0]) l0_q <= f0(frame_vec);
    if (stage_en[1]) l1_q <= f1(l0_q);
    if (stage_en[2]) l2_q <= f2(l1_q);
  end
  assign net_out = l2_q;

  int            n_vec = 0, n_mis = 0;
  int            cyc = 0, rd_idx = 0, hs_cnt = 0, hs_base = 0, fe_cnt = 0, fe_base = 0;
  int            exp_err = 0;
  logic [OW-1:0] exp_q[$];
  int            hs_cyc[$];
  logic [FW-1:0] fb[0:31];
  bit            rand_rdy = 0;
  bit            prev_stall = 0;
  logic [OW-1:0] prev_data;
  logic          sv_sready, sv_mv, sv_fe;
  logic [NL-1:0] sv_en;
  logic [OW-1:0] sv_md;
  logic [VW-1:0] sv_vec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, check the output side, return at posedge+1.
  task automatic tick();
    logic [CW-1:0] exp_fc, exp_ec;
    @(negedge clk);
    cyc++;
    sv_sready = s_ready; sv_mv = m_valid; sv_fe = frame_err;
    sv_en = stage_en; sv_md = m_data; sv_vec = frame_vec;
    if (sv_fe) fe_cnt++;
`ifdef LUTNET_SEQ_STATS_EN
    exp_fc = CW'(hs_cnt - hs_base);
    exp_ec = CW'(fe_cnt - fe_base);
`else
    exp_fc = '0;
    exp_ec = '0;
`endif
    chk("frame_cnt", frame_cnt, exp_fc);
    chk("err_cnt", err_cnt, exp_ec);
    if (prev_stall) begin
      chk("stall_mvalid_held", sv_mv, 1'b1);
      chk("stall_mdata_held", sv_md, prev_data);
    end
    if (sv_mv && !m_ready) chk("stall_stage_en", sv_en, '0);
    if (sv_mv && m_ready) begin
      if (rd_idx < exp_q.size()) chk("m_data", sv_md, exp_q[rd_idx]);
      else chk("spurious_mvalid", sv_mv, 1'b0);
      rd_idx++;
      hs_cnt++;
      hs_cyc.push_back(cyc);
    end
    prev_stall = sv_mv && !m_ready;
    prev_data  = sv_md;
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = 1'($urandom);
  endtask

  task automatic send_range(input int lo, input int hi, input int last_at);
    for (int i = lo; i <= hi; i++) begin
      int   n;
      logic acc;
      s_valid = 1'b1; s_data = fb[i]; s_last = (i == last_at);
      n = 0; acc = 1'b0;
      while (!acc && n < 64) begin
        tick();
        acc = sv_sready;
        n++;
      end
      chk("beat_accept", acc, 1'b1);
    end
    s_last = 1'b0;
  endtask

  function automatic logic [VW-1:0] pack_frame();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NF; i++) v[i*FW +: FW] = fb[i];
    return v;
  endfunction

  task automatic rand_fill(input int n);
    for (int i = 0; i < n; i++) fb[i] = FW'($urandom);
  endtask

  task automatic good_frame();
    send_range(0, NF-1, NF-1);
    exp_q.push_back(ref_class(pack_frame()));
  endtask

  task automatic drain();
    int n = 0;
    s_valid = 1'b0;
    while (rd_idx < exp_q.size() && n < 400) begin
      tick();
      n++;
    end
    chk("drain_done", rd_idx, exp_q.size());
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    #12;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_stage_en", stage_en, '0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_frame_vec", frame_vec, '0);
    chk("rst_frame_cnt", frame_cnt, '0);
    chk("rst_err_cnt", err_cnt, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed frame i%4: latency and enable timing
    for (int i = 0; i < NF; i++) fb[i] = FW'(i % 4);
    good_frame();
    s_valid = 1'b0;
    tick();
    chk("t1_s_ready_launch", sv_sready, 1'b0);
    chk("t1_stage_en0", sv_en, 3'b001);
    chk("t1_frame_vec", sv_vec, 32'hE4E4E4E4);
    tick(); chk("t2_stage_en1", sv_en, 3'b010);
    tick(); chk("t3_stage_en2", sv_en, 3'b100);
    tick(); chk("t4_m_valid", sv_mv, 1'b1);
    tick(); chk("t5_m_valid_low", sv_mv, 1'b0);
    drain();

    // Backpressure: two frames, output stalled long enough to hold the second launch
    m_ready = 1'b0;
    rand_fill(NF); good_frame();
    rand_fill(NF); good_frame();
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_launch_held", sv_sready, 1'b0);
      chk("stall_mv", sv_mv, 1'b1);
    end
    m_ready = 1'b1;
    drain();

    // Short frame: last on beat 5
    rand_fill(6);
    send_range(0, 5, 5);
    s_valid = 1'b0;
    exp_err++;
    tick(); chk("short_frame_err", sv_fe, 1'b1);
    tick(); chk("short_frame_err_pulse", sv_fe, 1'b0);
    chk("short_no_mvalid", sv_mv, 1'b0);
    rand_fill(NF); good_frame(); drain();

    // Long frame: 20 beats, last on beat 19
    rand_fill(20);
    send_range(0, 15, -1);
    s_valid = 1'b0;
    exp_err++;
    tick(); chk("long_frame_err", sv_fe, 1'b1);
    send_range(16, 19, 19);
    s_valid = 1'b0;
    tick(); chk("long_resync_exit", sv_sready, 1'b1);
    chk("long_frame_err_once", sv_fe, 1'b0);
    rand_fill(NF); good_frame(); drain();

    // Back-to-back frames at full rate
    for (int f = 0; f < 3; f++) begin
      rand_fill(NF); good_frame();
    end
    drain();
    chk("b2b_period_a", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], 17);
    chk("b2b_period_b", hs_cyc[hs_cyc.size()-2] - hs_cyc[hs_cyc.size()-3], 17);

    // Random output backpressure
    rand_rdy = 1'b1;
    for (int f = 0; f < 4; f++) begin
      rand_fill(NF); good_frame();
    end
    drain();
    rand_rdy = 1'b0; m_ready = 1'b1;
    tick();

    // Reset with a token stalled at the output and a partial frame collected
    m_ready = 1'b0;
    rand_fill(NF); send_range(0, NF-1, NF-1);
    rand_fill(7); send_range(0, 6, -1);
    s_valid = 1'b0;
    tick(); chk("pre_rst_mvalid", sv_mv, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_s_ready", s_ready, 1'b1);
    chk("arst_stage_en", stage_en, '0);
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_frame_err", frame_err, 1'b0);
    chk("arst_frame_vec", frame_vec, '0);
    chk("arst_frame_cnt", frame_cnt, '0);
    chk("arst_err_cnt", err_cnt, '0);
    hs_base = hs_cnt; fe_base = fe_cnt; exp_err = 0;
    prev_stall = 0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_no_mvalid", sv_mv, 1'b0);
    end
    rand_fill(NF); good_frame();
    s_valid = 1'b0;
    tick(); chk("post_rst_frame_vec", sv_vec, pack_frame());
    drain();
    chk("frame_err_total", fe_cnt - fe_base, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
